// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MC_BNE_EN adds bne (opcode 000101) through the BRANCH state.
module mips_mc_controller #(
    parameter int N_STATE_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              op,
    input  logic [5:0]              funct,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    iord,
    output logic                    memwrite,
    output logic                    irwrite,
    output logic                    regdst,
    output logic                    memtoreg,
    output logic                    regwrite,
    output logic                    alusrca,
    output logic [1:0]              alusrcb,
    output logic [1:0]              pcsrc,
    output logic                    pcen,
    output logic [2:0]              alu_control,
    output logic                    illegal_op,
    output logic [N_STATE_BITS-1:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    state_t state, state_nx;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            6'b100111: funct_alu = 3'b100;
            default:   funct_alu = 3'b011;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010, 6'b100111: funct_ok = 1'b1;
            default:                         funct_ok = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nx;
    end

`ifdef MC_BNE_EN
    // Branch polarity is latched in DECODE so BRANCH does not depend on op.
    logic bne_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 bne_q <= 1'b0;
        else if (state == S_DECODE) bne_q <= (op == OP_BNE);
    end
`endif

    always_comb begin
        state_nx    = S_RESET;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcen        = 1'b0;
        alu_control = 3'b000;
        illegal_op  = 1'b0;
        case (state)
            S_RESET: state_nx = S_FETCH;
            S_FETCH: begin
                alusrcb     = 2'b01;
                alu_control = 3'b010;
                irwrite     = mem_ready;
                pcen        = mem_ready;
                state_nx    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb     = 2'b11;
                alu_control = 3'b010;
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_nx = S_BRANCH;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_nx   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca     = 1'b1;
                alusrcb     = 2'b10;
                alu_control = 3'b010;
                state_nx    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_nx = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_nx = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca     = 1'b1;
                alu_control = funct_alu(funct);
                state_nx    = S_ALUWB;
            end
            S_ALUWB: begin
                // funct is read live; the IR holds because irwrite is low here.
                regdst     = 1'b1;
                regwrite   = funct_ok(funct);
                illegal_op = ~funct_ok(funct);
                state_nx   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                alu_control = 3'b110;
                pcsrc       = 2'b01;
`ifdef MC_BNE_EN
                pcen        = bne_q ? ~zero : zero;
`else
                pcen        = zero;
`endif
                state_nx    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca     = 1'b1;
                alusrcb     = 2'b10;
                alu_control = 3'b010;
                state_nx    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_nx = S_FETCH;
            end
            S_JUMP: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_RESET;
        endcase
    end

    assign state_o = N_STATE_BITS'(state);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: directed instruction sequences, per-cycle
// expected state/output vectors queued by the driver and checked by a monitor.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    mips_mc_controller #(.N_STATE_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alu_control(alu_control),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // State codes
    localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, MAD = 4'd3, MRD = 4'd4,
                           MWB = 4'd5, MWR = 4'd6, EXE = 4'd7, AWB = 4'd8, BRA = 4'd9,
                           AEX = 4'd10, AWB2 = 4'd11, JMP = 4'd12;

    // Output order: iord memwrite irwrite regdst memtoreg regwrite alusrca
    //               alusrcb[2] pcsrc[2] pcen alu_control[3] illegal_op
    localparam logic [15:0] V_RESET  = 16'b0_0_0_0_0_0_0_00_00_0_000_0;
    localparam logic [15:0] V_FETCH  = 16'b0_0_1_0_0_0_0_01_00_1_010_0;
    localparam logic [15:0] V_FWAIT  = 16'b0_0_0_0_0_0_0_01_00_0_010_0;
    localparam logic [15:0] V_DEC    = 16'b0_0_0_0_0_0_0_11_00_0_010_0;
    localparam logic [15:0] V_DECIL  = 16'b0_0_0_0_0_0_0_11_00_0_010_1;
    localparam logic [15:0] V_MADR   = 16'b0_0_0_0_0_0_1_10_00_0_010_0;
    localparam logic [15:0] V_MRD    = 16'b1_0_0_0_0_0_0_00_00_0_000_0;
    localparam logic [15:0] V_MWB    = 16'b0_0_0_0_1_1_0_00_00_0_000_0;
    localparam logic [15:0] V_MWR    = 16'b1_1_0_0_0_0_0_00_00_0_000_0;
    localparam logic [15:0] V_EXSUB  = 16'b0_0_0_0_0_0_1_00_00_0_110_0;
    localparam logic [15:0] V_EXSLT  = 16'b0_0_0_0_0_0_1_00_00_0_111_0;
    localparam logic [15:0] V_EXBAD  = 16'b0_0_0_0_0_0_1_00_00_0_011_0;
    localparam logic [15:0] V_EXADD  = 16'b0_0_0_0_0_0_1_00_00_0_010_0;
    localparam logic [15:0] V_AWB    = 16'b0_0_0_1_0_1_0_00_00_0_000_0;
    localparam logic [15:0] V_AWBIL  = 16'b0_0_0_1_0_0_0_00_00_0_000_1;
    localparam logic [15:0] V_BR1    = 16'b0_0_0_0_0_0_1_00_01_1_110_0;
    localparam logic [15:0] V_BR0    = 16'b0_0_0_0_0_0_1_00_01_0_110_0;
    localparam logic [15:0] V_AEX    = 16'b0_0_0_0_0_0_1_10_00_0_010_0;
    localparam logic [15:0] V_AWB2   = 16'b0_0_0_0_0_1_0_00_00_0_000_0;
    localparam logic [15:0] V_JMP    = 16'b0_0_0_0_0_0_0_00_10_1_000_0;

    typedef struct {
        logic [19:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [19:0] act;
            e   = q.pop_front();
            act = {state_o, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, pcen, alu_control, illegal_op};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
                         e.nm, act[19:16], act[15:0], e.v[19:16], e.v[15:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr, input logic [3:0] st,
                        input logic [15:0] ex, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = mr;
        e.v  = {st, ex};
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic rtype(input logic [5:0] f, input logic [15:0] vex,
                         input logic [15:0] vwb, input string nm);
        step(1, 6'b000000, f, 0, 1, FET, V_FETCH, {nm, "_fetch"});
        step(1, 6'b000000, f, 0, 1, DEC, V_DEC,   {nm, "_decode"});
        step(1, 6'b000000, f, 0, 1, EXE, vex,     {nm, "_exec"});
        step(1, 6'b000000, f, 0, 1, AWB, vwb,     {nm, "_aluwb"});
    endtask

    initial begin
        // Reset held for 3 cycles, then released; state stays RESET until next edge
        repeat (3) step(0, 6'd0, 6'd0, 0, 1, RST, V_RESET, "reset_hold");
        step(1, 6'd0, 6'd0, 0, 1, RST, V_RESET, "reset_release");

        // lw, mem_ready high: 5 cycles
        step(1, 6'b100011, 0, 0, 1, FET, V_FETCH, "lw_fetch");
        step(1, 6'b100011, 0, 0, 1, DEC, V_DEC,   "lw_decode");
        step(1, 6'b100011, 0, 0, 1, MAD, V_MADR,  "lw_memadr");
        step(1, 6'b100011, 0, 0, 1, MRD, V_MRD,   "lw_memrd");
        step(1, 6'b100011, 0, 0, 1, MWB, V_MWB,   "lw_memwb");

        // sw with 3 stall cycles in MEMWR, plus a FETCH stall first
        step(1, 6'b101011, 0, 0, 0, FET, V_FWAIT, "sw_fetch_wait");
        step(1, 6'b101011, 0, 0, 1, FET, V_FETCH, "sw_fetch");
        step(1, 6'b101011, 0, 0, 1, DEC, V_DEC,   "sw_decode");
        step(1, 6'b101011, 0, 0, 1, MAD, V_MADR,  "sw_memadr");
        step(1, 6'b101011, 0, 0, 0, MWR, V_MWR,   "sw_memwr_w1");
        step(1, 6'b101011, 0, 0, 0, MWR, V_MWR,   "sw_memwr_w2");
        step(1, 6'b101011, 0, 0, 0, MWR, V_MWR,   "sw_memwr_w3");
        step(1, 6'b101011, 0, 0, 1, MWR, V_MWR,   "sw_memwr_done");

        // R-type
        rtype(6'b100010, V_EXSUB, V_AWB,   "r_sub");
        rtype(6'b101010, V_EXSLT, V_AWB,   "r_slt");
        rtype(6'b111111, V_EXBAD, V_AWBIL, "r_bad");
        rtype(6'b100000, V_EXADD, V_AWB,   "r_add");

        // beq taken / not taken
        step(1, 6'b000100, 0, 1, 1, FET, V_FETCH, "beq1_fetch");
        step(1, 6'b000100, 0, 1, 1, DEC, V_DEC,   "beq1_decode");
        step(1, 6'b000100, 0, 1, 1, BRA, V_BR1,   "beq1_branch");
        step(1, 6'b000100, 0, 0, 1, FET, V_FETCH, "beq0_fetch");
        step(1, 6'b000100, 0, 0, 1, DEC, V_DEC,   "beq0_decode");
        step(1, 6'b000100, 0, 0, 1, BRA, V_BR0,   "beq0_branch");

        // addi
        step(1, 6'b001000, 0, 0, 1, FET,  V_FETCH, "addi_fetch");
        step(1, 6'b001000, 0, 0, 1, DEC,  V_DEC,   "addi_decode");
        step(1, 6'b001000, 0, 0, 1, AEX,  V_AEX,   "addi_ex");
        step(1, 6'b001000, 0, 0, 1, AWB2, V_AWB2,  "addi_wb");

        // j
        step(1, 6'b000010, 0, 0, 1, FET, V_FETCH, "j_fetch");
        step(1, 6'b000010, 0, 0, 1, DEC, V_DEC,   "j_decode");
        step(1, 6'b000010, 0, 0, 1, JMP, V_JMP,   "j_jump");

        // undecodable opcode
        step(1, 6'b111111, 0, 0, 1, FET, V_FETCH, "ill_fetch");
        step(1, 6'b111111, 0, 0, 1, DEC, V_DECIL, "ill_decode");

        // bne
`ifdef MC_BNE_EN
        step(1, 6'b000101, 0, 0, 1, FET, V_FETCH, "bne0_fetch");
        step(1, 6'b000101, 0, 0, 1, DEC, V_DEC,   "bne0_decode");
        step(1, 6'b000101, 0, 0, 1, BRA, V_BR1,   "bne0_branch");
        step(1, 6'b000101, 0, 1, 1, FET, V_FETCH, "bne1_fetch");
        step(1, 6'b000101, 0, 1, 1, DEC, V_DEC,   "bne1_decode");
        step(1, 6'b000101, 0, 1, 1, BRA, V_BR0,   "bne1_branch");
`else
        step(1, 6'b000101, 0, 0, 1, FET, V_FETCH, "bne_fetch");
        step(1, 6'b000101, 0, 0, 1, DEC, V_DECIL, "bne_decode_illegal");
`endif

        // lw with 2 stall cycles in MEMRD
        step(1, 6'b100011, 0, 0, 1, FET, V_FETCH, "lws_fetch");
        step(1, 6'b100011, 0, 0, 1, DEC, V_DEC,   "lws_decode");
        step(1, 6'b100011, 0, 0, 1, MAD, V_MADR,  "lws_memadr");
        step(1, 6'b100011, 0, 0, 0, MRD, V_MRD,   "lws_memrd_w1");
        step(1, 6'b100011, 0, 0, 0, MRD, V_MRD,   "lws_memrd_w2");
        step(1, 6'b100011, 0, 0, 1, MRD, V_MRD,   "lws_memrd_done");
        step(1, 6'b100011, 0, 0, 1, MWB, V_MWB,   "lws_memwb");

        // sw interrupted by async reset in its 2nd MEMWR cycle
        step(1, 6'b101011, 0, 0, 1, FET, V_FETCH, "swr_fetch");
        step(1, 6'b101011, 0, 0, 1, DEC, V_DEC,   "swr_decode");
        step(1, 6'b101011, 0, 0, 1, MAD, V_MADR,  "swr_memadr");
        step(1, 6'b101011, 0, 0, 0, MWR, V_MWR,   "swr_memwr_w1");
        step(0, 6'b101011, 0, 0, 0, RST, V_RESET, "swr_reset_mid");
        step(1, 6'b101011, 0, 0, 1, RST, V_RESET, "swr_release");
        step(1, 6'b100011, 0, 0, 1, FET, V_FETCH, "swr_refetch");

        // Drain, bounded
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
